udp_builder: RTL and testbench
==============================

UDP_BUILDER -- requirements
Module: udp_builder

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 8, byte width.
- BUFFER_SIZE, 2048, payload buffer depth.
- MAX_PAYLOAD, 1472, payload byte limit.
- ETH_DST_ADDR, 48'hFFFFFFFFFFFF, destination MAC.
- ETH_SRC_ADDR, 48'h000000000001, source MAC.
- IP_SRC_ADDR, 32'h0A000001, source IP.
- IP_DST_ADDR, 32'h0A000002, destination IP.
- UDP_SRC_PORT, 16'h1000, source port.
- UDP_DST_PORT, 16'h2000, destination port.
- IP_TTL, 8'h40, time-to-live.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single clock.
- reset, in, 1, asynchronous active-high reset.
- in_sof, in, 1, marks the first payload byte.
- in_eof, in, 1, marks the last payload byte.
- din, in, 8, payload byte.
- empty, in, 1, input FIFO empty.
- in_rd_en, out, 1, input byte consumed.
- dout, out, 8, frame byte.
- out_sof, out, 1, marks the first frame byte.
- out_eof, out, 1, marks the last frame byte.
- full, in, 1, output FIFO full.
- out_wr_en, out, 1, frame byte written.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high, named reset, with the clock named clock.

Function
REQ-004 States SHALL be IDLE, CAPTURE, CKSUM_FOLD, CKSUM_DONE, HEADER, PAYLOAD.
REQ-005 IDLE:
- empty=0, in_sof=0: assert in_rd_en, discard the byte.
- empty=0, in_sof=1: go to CAPTURE without consuming the byte.
REQ-006 CAPTURE, per cycle with empty=0:
- Assert in_rd_en and write din to the internal payload buffer.
- Increment N (16-bit byte count).
- Accumulate the 17-bit one's-complement sum: even-index byte is the high byte, odd-index byte the low byte.
- Add the end-around carry at each word add.
- empty=1: hold all state.
REQ-007 in_sof inside CAPTURE SHALL be ignored; the byte is payload.
REQ-008 Bytes beyond MAX_PAYLOAD SHALL be consumed and discarded up to and including in_eof; they are not counted or summed.
REQ-009 The consumed byte with in_eof=1 SHALL end CAPTURE (cycle T).
- An odd trailing byte SHALL be summed as {byte, 8'h00}.
- The next state SHALL be CKSUM_FOLD.
REQ-010 CKSUM_FOLD (T+1) SHALL add pseudo-header and header words to the UDP sum: IP_SRC_ADDR, IP_DST_ADDR, 16'h0011, UDP length twice, both ports.
- UDP length SHALL be N+8.
REQ-011 CKSUM_FOLD SHALL compute the IPv4 header sum over 20 bytes with the checksum field zero.
- IP total length SHALL be N+28.
REQ-012 CKSUM_DONE (T+2) SHALL fold carries and complement both sums.
- A UDP checksum of 16'h0000 SHALL be sent as 16'hFFFF.
REQ-013 HEADER SHALL emit 42 bytes, most-significant byte first, in this order:
- ETH_DST_ADDR, ETH_SRC_ADDR, 16'h0800.
- 8'h45, 8'h00, IP total length, ID, 16'h4000, IP_TTL, 8'h11, IP checksum.
- IP_SRC_ADDR, IP_DST_ADDR.
- UDP_SRC_PORT, UDP_DST_PORT, UDP length, UDP checksum.
REQ-014 A byte SHALL be written only when full=0: out_wr_en=1 with dout valid in that cycle.
- full=1: out_wr_en=0, index held.
- The first header byte SHALL be offered at T+3.
REQ-015 out_sof SHALL be 1 only with the first header byte.
REQ-016 PAYLOAD SHALL emit N buffered bytes in arrival order, under the same full rule.
- out_eof SHALL be 1 only with the last payload byte.
- The next state SHALL be IDLE.
REQ-017 in_rd_en SHALL be 0 in CKSUM_FOLD, CKSUM_DONE, HEADER and PAYLOAD.
REQ-018 The 16-bit ID SHALL increment after each out_eof and wrap 16'hFFFF to 16'h0000.
REQ-019 in_sof and in_eof on the same byte SHALL form a 1-byte packet.

Reset
REQ-020 On reset:
- State SHALL be IDLE; N, sums, buffer pointers and ID SHALL be 0.
- in_rd_en, out_wr_en, out_sof, out_eof SHALL be 0 and dout SHALL be 8'h00.
REQ-021 Reset mid-packet SHALL discard the packet; no further bytes of it are emitted.

Verification
REQ-022 Payload 01 02 03 04, full=0 -> 46 bytes out, first at T+3:
- Bytes 16-17 = 00 20; bytes 38-39 = 00 0C.
- ID = 0000; both checksums match the model.
REQ-023 Payload AA BB CC (odd) -> UDP length 000B, IP length 001F; UDP checksum computed with CC00 padding.
REQ-024 Two back-to-back packets -> IDs 0000 then 0001; idle bytes without in_sof before packet 2 are discarded, not emitted.
REQ-025 full toggled every other cycle during a 10-byte packet -> exactly 52 out_wr_en pulses, no byte lost or duplicated, out_sof/out_eof once each.
REQ-026 Payload crafted for raw UDP checksum 0000 -> FFFF sent; 1500-byte payload -> 1472 sent, UDP length 05C8.
REQ-027 Reset asserted during HEADER byte 10 -> outputs 0 next cycle; a following 2-byte packet emits normally with ID 0000.

Source files
------------

// File: rtl/udp_builder.sv
`default_nettype none
// ============================================================================
// Module   : udp_builder
// Purpose  : Captures one payload packet from an input byte FIFO, computes the
//            IPv4 header and UDP checksums, then emits a complete
//            Ethernet/IPv4/UDP frame (42 header bytes + payload) into an
//            output byte FIFO.
// Ports    : clock, reset      - single clock, asynchronous active-high reset
//            in_sof/in_eof/din - payload byte and its first/last markers
//            empty/in_rd_en    - input FIFO empty flag / byte consumed strobe
//            dout/out_sof/out_eof - frame byte and its first/last markers
//            full/out_wr_en    - output FIFO full flag / byte written strobe
// Revision : 1.0 - initial release
// ============================================================================
module udp_builder #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          BUFFER_SIZE  = 2048,
  parameter int          MAX_PAYLOAD  = 1472,
  parameter logic [47:0] ETH_DST_ADDR = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] ETH_SRC_ADDR = 48'h000000000001,
  parameter logic [31:0] IP_SRC_ADDR  = 32'h0A000001,
  parameter logic [31:0] IP_DST_ADDR  = 32'h0A000002,
  parameter logic [15:0] UDP_SRC_PORT = 16'h1000,
  parameter logic [15:0] UDP_DST_PORT = 16'h2000,
  parameter logic [7:0]  IP_TTL       = 8'h40
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_sof,
  output logic                  out_eof,
  input  logic                  full,
  output logic                  out_wr_en
);

  localparam int          AW        = $clog2(BUFFER_SIZE);
  localparam logic [15:0] MAX_BYTES = 16'(MAX_PAYLOAD);
  localparam logic [5:0]  HDR_LAST  = 6'd41;
  localparam int          HDR_BITS  = 336;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CAPTURE    = 3'd1,
    CKSUM_FOLD = 3'd2,
    CKSUM_DONE = 3'd3,
    HEADER     = 3'd4,
    PAYLOAD    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           n_q, n_d;        // captured payload byte count
  logic [16:0]           sum_q, sum_d;    // running payload sum, bit 16 = pending carry
  logic [15:0]           rd_q, rd_d;      // payload read pointer
  logic [5:0]            idx_q, idx_d;    // header byte index
  logic [15:0]           id_q, id_d;      // IPv4 identification
  logic [31:0]           usum_q, usum_d;  // unfolded UDP sum
  logic [31:0]           isum_q, isum_d;  // unfolded IPv4 header sum
  logic [15:0]           ucks_q, ucks_d;
  logic [15:0]           icks_q, icks_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] pbuf_q [BUFFER_SIZE];

  logic [15:0]           udp_len;
  logic [15:0]           ip_len;
  logic [15:0]           ucks_raw;
  logic [HDR_BITS-1:0]   hdr;
  logic [8:0]            hdr_pos;

  // One's-complement add with the previous end-around carry folded back in.
  function automatic logic [16:0] add1c(input logic [16:0] acc, input logic [15:0] word);
    return {1'b0, acc[15:0]} + {16'h0000, acc[16]} + {1'b0, word};
  endfunction

  function automatic logic [31:0] w32(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  // Two folds always suffice for a 32-bit accumulator; the second cannot carry.
  function automatic logic [15:0] fold_cpl(input logic [31:0] s);
    logic [16:0] f1;
    logic [15:0] f2;
    f1 = {1'b0, s[15:0]} + {1'b0, s[31:16]};
    f2 = f1[15:0] + {15'h0000, f1[16]};
    return ~f2;
  endfunction

  assign udp_len  = n_q + 16'd8;
  assign ip_len   = n_q + 16'd28;
  assign ucks_raw = fold_cpl(usum_q);

  assign hdr = {ETH_DST_ADDR, ETH_SRC_ADDR, 16'h0800,
                8'h45, 8'h00, ip_len, id_q, 16'h4000, IP_TTL, 8'h11, icks_q,
                IP_SRC_ADDR, IP_DST_ADDR,
                UDP_SRC_PORT, UDP_DST_PORT, udp_len, ucks_q};

  // Header byte 0 lives in the most significant byte of hdr.
  assign hdr_pos = {HDR_LAST - idx_q, 3'b000};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      sum_q   <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      id_q    <= '0;
      usum_q  <= '0;
      isum_q  <= '0;
      ucks_q  <= '0;
      icks_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      usum_q  <= usum_d;
      isum_q  <= isum_d;
      ucks_q  <= ucks_d;
      icks_q  <= icks_d;
    end
  end

  // Payload storage carries no reset; only its pointers do.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      pbuf_q[n_q[AW-1:0]] <= din;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    sum_d     = sum_q;
    rd_d      = rd_q;
    idx_d     = idx_q;
    id_d      = id_q;
    usum_d    = usum_q;
    isum_d    = isum_q;
    ucks_d    = ucks_q;
    icks_d    = icks_q;
    mem_we    = 1'b0;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    dout      = '0;

    case (state_q)
      IDLE: begin
        n_d   = '0;
        sum_d = '0;
        rd_d  = '0;
        idx_d = '0;
        if (!empty) begin
          if (in_sof) begin
            state_d = CAPTURE;  // leave the first byte for CAPTURE to take
          end else begin
            in_rd_en = 1'b1;    // stray byte outside a packet
          end
        end
      end

      CAPTURE: begin
        if (!empty) begin
          in_rd_en = 1'b1;
          if (n_q < MAX_BYTES) begin
            mem_we = 1'b1;
            n_d    = n_q + 16'd1;
            // Even-index bytes are high halves; a lone trailing byte is thus padded.
            sum_d  = add1c(sum_q, n_q[0] ? {8'h00, din} : {din, 8'h00});
          end
          if (in_eof) begin
            state_d = CKSUM_FOLD;
          end
        end
      end

      CKSUM_FOLD: begin
        usum_d = {15'h0000, sum_q}
               + w32(IP_SRC_ADDR[31:16]) + w32(IP_SRC_ADDR[15:0])
               + w32(IP_DST_ADDR[31:16]) + w32(IP_DST_ADDR[15:0])
               + w32(16'h0011) + w32(udp_len) + w32(udp_len)
               + w32(UDP_SRC_PORT) + w32(UDP_DST_PORT);
        isum_d = w32(16'h4500) + w32(ip_len) + w32(id_q) + w32(16'h4000)
               + w32({IP_TTL, 8'h11})
               + w32(IP_SRC_ADDR[31:16]) + w32(IP_SRC_ADDR[15:0])
               + w32(IP_DST_ADDR[31:16]) + w32(IP_DST_ADDR[15:0]);
        state_d = CKSUM_DONE;
      end

      CKSUM_DONE: begin
        icks_d  = fold_cpl(isum_q);
        // A zero UDP checksum means "none", so it is transmitted as all ones.
        ucks_d  = (ucks_raw == 16'h0000) ? 16'hFFFF : ucks_raw;
        state_d = HEADER;
      end

      HEADER: begin
        dout = hdr[hdr_pos +: 8];
        if (!full) begin
          out_wr_en = 1'b1;
          out_sof   = (idx_q == 6'd0);
          if (idx_q == HDR_LAST) begin
            idx_d   = '0;
            state_d = PAYLOAD;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      PAYLOAD: begin
        dout = pbuf_q[rd_q[AW-1:0]];
        if (!full) begin
          out_wr_en = 1'b1;
          rd_d      = rd_q + 16'd1;
          if (rd_q == n_q - 16'd1) begin
            out_eof = 1'b1;
            id_d    = id_q + 16'd1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Strobes stay quiet while reset is held, whatever the inputs show.
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      out_sof   = 1'b0;
      out_eof   = 1'b0;
      dout      = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_builder
// Purpose  : Self-checking bench for udp_builder. Payloads are pushed into a
//            modelled input FIFO; expected frames are built from the
//            Ethernet/IPv4/UDP layout and RFC 1071 checksums and compared
//            against every byte the design writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_builder;

  localparam logic [47:0] ETH_DST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] ETH_SRC = 48'h000000000001;
  localparam logic [31:0] SRC_IP  = 32'h0A000001;
  localparam logic [31:0] DST_IP  = 32'h0A000002;
  localparam int          MAXP    = 1472;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] d;
  } ib_t;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    int         cyc;
  } ob_t;

  logic       clock;
  logic       reset;
  logic       in_sof;
  logic       in_eof;
  logic [7:0] din;
  logic       empty;
  logic       in_rd_en;
  logic [7:0] dout;
  logic       out_sof;
  logic       out_eof;
  logic       full;
  logic       out_wr_en;

  ib_t        inq[$];
  ib_t        exp_q[$];
  ob_t        cap_q[$];
  logic [7:0] pl[$];
  logic [7:0] fq[$];

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          eof_cyc;
  bit          pop_pending;
  bit          stall_en;
  int          full_mode;
  logic [15:0] exp_id;

  udp_builder dut (
    .clock    (clock),
    .reset    (reset),
    .in_sof   (in_sof),
    .in_eof   (in_eof),
    .din      (din),
    .empty    (empty),
    .in_rd_en (in_rd_en),
    .dout     (dout),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .full     (full),
    .out_wr_en(out_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fold(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    while (t[31:16] != 16'h0000) t = {16'h0000, t[15:0]} + {16'h0000, t[31:16]};
    return t[15:0];
  endfunction

  // Pseudo-header + UDP header + payload, as a folded one's-complement sum.
  function automatic logic [15:0] udp_raw(input int n);
    logic [31:0] s;
    logic [15:0] ul;
    ul = 16'(n + 8);
    s  = 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0])
       + 32'h0011 + 32'(ul) + 32'(ul) + 32'h1000 + 32'h2000;
    for (int i = 0; i < n; i += 2)
      s += {16'h0000, pl[i], (i + 1 < n) ? pl[i + 1] : 8'h00};
    return fold(s);
  endfunction

  task automatic putn(input logic [47:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) fq.push_back(v[8*k +: 8]);
  endtask

  task automatic make_rand(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  task automatic push_garbage(input int nb);
    ib_t b;
    for (int i = 0; i < nb; i++) begin
      b.sof = 1'b0;
      b.eof = 1'($urandom_range(0, 1));
      b.d   = 8'($urandom);
      inq.push_back(b);
    end
  endtask

  // Queue pl as an input packet and append its expected frame to exp_q.
  task automatic push_pkt(input bit rand_sof);
    int          n;
    logic [15:0] ul, il, ick, uck;
    logic [31:0] s;
    ib_t         b;
    for (int i = 0; i < pl.size(); i++) begin
      b.d   = pl[i];
      b.sof = (i == 0) || (rand_sof && $urandom_range(0, 7) == 0);
      b.eof = (i == pl.size() - 1);
      inq.push_back(b);
    end
    n   = (pl.size() > MAXP) ? MAXP : pl.size();
    ul  = 16'(n + 8);
    il  = 16'(n + 28);
    s   = 32'h4500 + 32'(il) + 32'(exp_id) + 32'h4000 + 32'h4011
        + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
    ick = ~fold(s);
    uck = ~udp_raw(n);
    if (uck == 16'h0000) uck = 16'hFFFF;
    fq.delete();
    putn(ETH_DST, 6); putn(ETH_SRC, 6); putn(48'h0800, 2);
    putn(48'h45, 1); putn(48'h00, 1); putn(48'(il), 2); putn(48'(exp_id), 2);
    putn(48'h4000, 2); putn(48'h40, 1); putn(48'h11, 1); putn(48'(ick), 2);
    putn(48'(SRC_IP), 4); putn(48'(DST_IP), 4);
    putn(48'h1000, 2); putn(48'h2000, 2); putn(48'(ul), 2); putn(48'(uck), 2);
    for (int i = 0; i < n; i++) fq.push_back(pl[i]);
    for (int i = 0; i < fq.size(); i++) begin
      b.d   = fq[i];
      b.sof = (i == 0);
      b.eof = (i == fq.size() - 1);
      exp_q.push_back(b);
    end
    exp_id++;
  endtask

  task automatic wait_out(input string tag);
    int budget;
    budget = 40 * exp_q.size() + 400;
    while (cap_q.size() < exp_q.size() && budget > 0) begin
      @(posedge clock); #2;
      budget--;
    end
    repeat (8) begin @(posedge clock); #2; end
    chk($sformatf("%s count", tag), 64'(cap_q.size()), 64'(exp_q.size()));
  endtask

  task automatic cmp_frames(input string tag);
    int m, idx;
    m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    if (m > 0) begin
      idx = m - 1;
      for (int i = m - 1; i >= 0; i--)
        if ({cap_q[i].sof, cap_q[i].eof, cap_q[i].d} !== exp_q[i]) idx = i;
      chk($sformatf("%s byte%0d", tag, idx),
          64'({cap_q[idx].sof, cap_q[idx].eof, cap_q[idx].d}), 64'(exp_q[idx]));
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [15:0] f16(input int i);
    if (i + 1 < cap_q.size()) return {cap_q[i].d, cap_q[i + 1].d};
    return 16'hxxxx;
  endfunction

  task automatic chk_quiet(input string tag);
    chk($sformatf("%s in_rd_en", tag), 64'(in_rd_en), 64'd0);
    chk($sformatf("%s out_wr_en", tag), 64'(out_wr_en), 64'd0);
    chk($sformatf("%s out_sof", tag), 64'(out_sof), 64'd0);
    chk($sformatf("%s out_eof", tag), 64'(out_eof), 64'd0);
    chk($sformatf("%s dout", tag), 64'(dout), 64'd0);
  endtask

  // Input FIFO / output FIFO model: drive just after the edge, sample mid-cycle.
  initial begin : drv
    ob_t o;
    forever begin
      @(posedge clock);
      #1;
      if (pop_pending && inq.size() > 0) void'(inq.pop_front());
      pop_pending = 1'b0;
      case (full_mode)
        0:       full = 1'b0;
        1:       full = ($urandom_range(0, 2) == 0);
        default: full = ~full;
      endcase
      if (inq.size() > 0 && !(stall_en && $urandom_range(0, 3) == 0)) begin
        empty  = 1'b0;
        in_sof = inq[0].sof;
        in_eof = inq[0].eof;
        din    = inq[0].d;
      end else begin
        empty  = 1'b1;
        in_sof = 1'b0;
        in_eof = 1'b0;
        din    = 8'($urandom);
      end
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (in_rd_en && !empty) begin
          pop_pending = 1'b1;
          if (in_eof) eof_cyc = cyc;
        end
        if (out_wr_en) begin
          o.d   = dout;
          o.sof = out_sof;
          o.eof = out_eof;
          o.cyc = cyc;
          cap_q.push_back(o);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] w, id0;
    int          n0, sofs, eofs, budget;
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    eof_cyc     = 0;
    pop_pending = 1'b0;
    stall_en    = 1'b0;
    full_mode   = 0;
    exp_id      = 16'h0000;
    reset       = 1'b1;
    empty       = 1'b1;
    full        = 1'b0;
    in_sof      = 1'b0;
    in_eof      = 1'b0;
    din         = 8'h00;

    // Reset with a stray byte waiting: nothing may be consumed or written.
    push_garbage(1);
    inq[0].eof = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk_quiet("reset");
    @(posedge clock); #2;
    reset = 1'b0;

    // Four-byte packet, output never full.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_pkt(1'b0);
    wait_out("A");
    if (cap_q.size() > 0) chk("A latency", 64'(cap_q[0].cyc - eof_cyc), 64'd3);
    chk("A ip_len", 64'(f16(16)), 64'h0020);
    chk("A ip_id", 64'(f16(18)), 64'h0000);
    chk("A udp_len", 64'(f16(38)), 64'h000C);
    cmp_frames("A");

    // Odd-length packet.
    pl = '{8'hAA, 8'hBB, 8'hCC};
    push_pkt(1'b0);
    wait_out("B");
    chk("B ip_len", 64'(f16(16)), 64'h001F);
    chk("B udp_len", 64'(f16(38)), 64'h000B);
    cmp_frames("B");

    // Back-to-back packets with stray bytes in front of each.
    id0 = exp_id;
    push_garbage(3);
    make_rand(5);
    push_pkt(1'b0);
    push_garbage(4);
    make_rand(7);
    push_pkt(1'b0);
    wait_out("C");
    chk("C id0", 64'(f16(18)), 64'(id0));
    chk("C id1", 64'(f16(47 + 18)), 64'(id0 + 16'd1));
    cmp_frames("C");

    // Output full every other cycle.
    full_mode = 2;
    make_rand(10);
    push_pkt(1'b0);
    wait_out("D");
    sofs = 0;
    eofs = 0;
    foreach (cap_q[i]) begin
      sofs += int'(cap_q[i].sof);
      eofs += int'(cap_q[i].eof);
    end
    chk("D wr pulses", 64'(cap_q.size()), 64'd52);
    chk("D sof count", 64'(sofs), 64'd1);
    chk("D eof count", 64'(eofs), 64'd1);
    cmp_frames("D");
    full_mode = 0;

    // Payload whose raw UDP checksum works out to zero.
    make_rand(8);
    pl[6] = 8'h00;
    pl[7] = 8'h00;
    w     = 16'hFFFF - udp_raw(8);
    pl[6] = w[15:8];
    pl[7] = w[7:0];
    push_pkt(1'b0);
    wait_out("E");
    chk("E udp_cksum", 64'(f16(40)), 64'hFFFF);
    cmp_frames("E");

    // Oversized payload is truncated.
    make_rand(1500);
    push_pkt(1'b0);
    wait_out("F");
    chk("F udp_len", 64'(f16(38)), 64'h05C8);
    cmp_frames("F");

    // Random packets with input stalls, output back-pressure and stray sof.
    full_mode = 1;
    stall_en  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_garbage($urandom_range(0, 3));
        make_rand($urandom_range(1, 80));
        push_pkt(1'b1);
      end
      wait_out($sformatf("G%0d", r));
      cmp_frames($sformatf("G%0d", r));
    end
    full_mode = 0;
    stall_en  = 1'b0;

    // Reset while header byte 10 is being offered.
    make_rand(20);
    push_pkt(1'b0);
    budget = 400;
    while (cap_q.size() < 10 && budget > 0) begin
      @(posedge clock); #2;
      budget--;
    end
    chk("H bytes before reset", 64'(cap_q.size()), 64'd10);
    reset       = 1'b1;
    inq.delete();
    pop_pending = 1'b0;
    empty       = 1'b1;
    in_sof      = 1'b0;
    in_eof      = 1'b0;
    @(negedge clock); #1;
    chk_quiet("H reset");
    @(posedge clock); #2;
    reset  = 1'b0;
    cap_q.delete();
    exp_q.delete();
    exp_id = 16'h0000;
    repeat (20) begin @(posedge clock); #2; end
    n0 = cap_q.size();
    chk("H residue", 64'(n0), 64'd0);
    cap_q.delete();
    pl = '{8'h5E, 8'hC3};
    push_pkt(1'b0);
    wait_out("H");
    chk("H ip_id", 64'(f16(18)), 64'h0000);
    cmp_frames("H");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
